// File: rtl/frqdiv_prog_if.sv
// rtl/frqdiv_prog_if.sv - control/status bundle for the programmable frequency divider
//
// Signals:
//   en       run enable (low stops the divider, output held low)
//   div_in   new divisor value, captured while div_load is high
//   div_load one-cycle request to capture div_in as the pending divisor
//   sync     one-cycle request to restart the output period at phase 0
//   s_out    divided clock output
//   tick     one-cycle pulse in the first cycle of each output period
//   div_ack  one-cycle pulse in the first cycle running a newly applied divisor
// Modports: master drives the controls, slave is the divider.
interface frqdiv_prog_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             sync;
    logic             s_out;
    logic             tick;
    logic             div_ack;

    modport master (
        output en, div_in, div_load, sync,
        input  s_out, tick, div_ack
    );

    modport slave (
        input  en, div_in, div_load, sync,
        output s_out, tick, div_ack
    );
endinterface

// File: rtl/frqdiv_prog.sv
// rtl/frqdiv_prog.sv - programmable clock divider with 50% duty for odd and even divisors
//
// Ports:
//   clk    single clock; phase logic on posedge, odd half-cycle stage on negedge
//   rst_n  asynchronous active-low reset
//   bus    frqdiv_prog_if.slave: en, div_in, div_load, sync in; s_out, tick, div_ack out
// Parameters:
//   WIDTH     width of divisor and phase counter
//   DIV_INIT  active divisor after reset
module frqdiv_prog #(
    parameter int WIDTH    = 16,
    parameter int DIV_INIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    frqdiv_prog_if.slave  bus
);

    logic [WIDTH-1:0] d_act;
    logic [WIDTH-1:0] d_pend;
    logic             pend;
    logic [WIDTH-1:0] cnt;
    logic             run;      // en as seen at the previous posedge
    logic             s_pos;    // posedge half of the output
    logic             s_neg;    // negedge half-cycle extension for odd divisors
    logic             en_neg;   // en retimed on negedge for the divide-by-1 gate
    logic             tick_r;
    logic             ack_r;

    logic             boundary;
    logic             apply;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] hi_start;

    always_comb begin
        boundary = run && (d_act >= WIDTH'(2)) && (cnt == d_act - WIDTH'(1));
        // Divisors 0 and 1 have no period boundary, so a pending value goes in at once.
        apply    = pend && (!bus.en || (d_act <= WIDTH'(1)) || bus.sync || boundary);
        d_next   = apply ? d_pend : d_act;
        // First posedge-high cycle: D/2 for even D, (D+1)/2 for odd D.
        hi_start = d_next - (d_next >> 1);
        if (!bus.en || bus.sync || !run || (d_next < WIDTH'(2)) || boundary || apply) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_act  <= WIDTH'(DIV_INIT);
            d_pend <= '0;
            pend   <= 1'b0;
            cnt    <= '0;
            run    <= 1'b0;
            s_pos  <= 1'b0;
            tick_r <= 1'b0;
            ack_r  <= 1'b0;
        end else begin
            d_act <= d_next;
            cnt   <= cnt_next;
            run   <= bus.en;
            // A load landing on the applying edge stays pending for the next one.
            if (bus.div_load) begin
                d_pend <= bus.div_in;
                pend   <= 1'b1;
            end else if (apply) begin
                pend   <= 1'b0;
            end
            ack_r  <= apply;
            s_pos  <= bus.en && (d_next >= WIDTH'(2)) && (cnt_next >= hi_start);
            tick_r <= bus.en && ((d_next == WIDTH'(1)) ||
                                 ((d_next >= WIDTH'(2)) && (cnt_next == '0)));
        end
    end

    // The negedge stage raises the output half a cycle early in cycle (D-1)/2,
    // giving an odd divisor exactly D/2 clk periods high.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_neg  <= 1'b0;
            en_neg <= 1'b0;
        end else begin
            s_neg  <= run && d_act[0] && (d_act >= WIDTH'(3)) && (cnt == (d_act >> 1));
            // Dropped one negedge ahead of a pending divisor change so the switch
            // away from divide-by-1 never cuts a clk high phase short.
            en_neg <= bus.en && (d_act == WIDTH'(1)) && !pend;
        end
    end

    assign bus.s_out   = s_pos | s_neg | (clk & en_neg);
    assign bus.tick    = tick_r;
    assign bus.div_ack = ack_r;

endmodule

// File: tb/tb_frqdiv_prog.sv
// tb/tb_frqdiv_prog.sv - directed vector bench for frqdiv_prog
module tb_frqdiv_prog;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frqdiv_prog_if #(.WIDTH(W)) bus ();

    frqdiv_prog #(.WIDTH(W), .DIV_INIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic         en;
        logic         ld;
        logic [W-1:0] din;
        logic         sy;
        logic         s1;   // s_out in clk-high half
        logic         s2;   // s_out in clk-low half
        logic         tk;
        logic         ak;
    } vec_t;

    vec_t vec[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic en, input logic ld, input logic [W-1:0] din, input logic sy,
                       input logic s1, input logic s2, input logic tk, input logic ak);
        vec_t v;
        v.en = en; v.ld = ld; v.din = din; v.sy = sy;
        v.s1 = s1; v.s2 = s2; v.tk = tk; v.ak = ak;
        vec.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clk cycle: outputs sampled 1 time unit after posedge and after negedge.
    task automatic step(output logic h1, output logic h2, output logic tk, output logic ak);
        @(posedge clk); #1;
        h1 = bus.s_out; tk = bus.tick; ak = bus.div_ack;
        @(negedge clk); #1;
        h2 = bus.s_out;
    endtask

    logic h1, h2, tk, ak;

    initial begin
        // en ld din sy | s_hi s_lo tick ack
        add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 1,1,0,0);
        add(1,0,0,0, 0,0,1,0); add(1,1,5,0, 0,0,0,0); add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 1,1,0,0);
        add(1,0,0,0, 0,0,1,1); add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,1,0,0); add(1,0,0,0, 1,1,0,0);
        add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,1,0,0);
        add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 1,1,0,0); add(1,1,6,0, 0,0,1,0); add(1,0,0,0, 0,0,0,0);
        add(1,0,0,0, 0,1,0,0); add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 0,0,1,1);
        add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 1,1,0,0);
        add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0);
        add(1,0,0,1, 0,0,1,0); add(1,0,0,0, 0,0,0,0); add(1,1,3,0, 0,0,0,0); add(1,0,0,0, 1,1,0,0);
        add(1,1,8,0, 1,1,0,0); add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 0,0,1,1); add(1,0,0,0, 0,0,0,0);
        add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 1,1,0,0);
        add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 1,1,0,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,0,0);
        add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 1,1,0,0); add(0,0,0,0, 0,0,0,0);
        add(0,0,0,0, 0,0,0,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,0,0);

        bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = '0; bus.sync = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset s_out", bus.s_out, 0);
        check("reset tick", bus.tick, 0);
        check("reset div_ack", bus.div_ack, 0);
        rst_n = 1'b1;

        foreach (vec[i]) begin
            bus.en = vec[i].en; bus.div_load = vec[i].ld; bus.div_in = vec[i].din; bus.sync = vec[i].sy;
            step(h1, h2, tk, ak);
            check($sformatf("row%0d s_out_hi", i), h1, vec[i].s1);
            check($sformatf("row%0d s_out_lo", i), h2, vec[i].s2);
            check($sformatf("row%0d tick", i), tk, vec[i].tk);
            check($sformatf("row%0d div_ack", i), ak, vec[i].ak);
        end
        bus.div_load = 1'b0; bus.sync = 1'b0;

        // Divide-by-1 loaded while stopped: applies without a boundary.
        bus.en = 1'b0; bus.div_load = 1'b1; bus.div_in = 1;
        step(h1, h2, tk, ak);
        check("d1 load ack early", ak, 0);
        bus.div_load = 1'b0;
        step(h1, h2, tk, ak);
        check("d1 apply ack", ak, 1);
        check("d1 stopped tick", tk, 0);
        check("d1 stopped s_out", h1, 0);
        bus.en = 1'b1;
        step(h1, h2, tk, ak);
        check("d1 run tick", tk, 1);
        step(h1, h2, tk, ak);
        check("d1 s_out follows clk hi", h1, 1);
        check("d1 s_out follows clk lo", h2, 0);
        check("d1 tick held", tk, 1);

        // en toggled inside clk-high phases: pulses stay whole, no runts.
        @(posedge clk); #2;
        bus.en = 1'b0;
        #2;
        check("d1 en fall pulse kept", bus.s_out, 1);
        @(negedge clk); #1;
        check("d1 en fall low", bus.s_out, 0);
        @(posedge clk); #1;
        check("d1 stopped no pulse", bus.s_out, 0);
        check("d1 stopped tick", bus.tick, 0);
        bus.en = 1'b1;
        #3;
        check("d1 en rise no runt", bus.s_out, 0);
        @(negedge clk); #1;
        check("d1 en rise lo", bus.s_out, 0);
        @(posedge clk); #1;
        check("d1 resumed pulse", bus.s_out, 1);
        check("d1 resumed tick", bus.tick, 1);

        // Divisor 0: everything quiet while en stays high.
        bus.div_load = 1'b1; bus.div_in = 0;
        @(posedge clk); #1;
        bus.div_load = 1'b0;
        step(h1, h2, tk, ak);
        check("d0 ack", ak, 1);
        check("d0 s_out hi", h1, 0);
        check("d0 s_out lo", h2, 0);
        check("d0 tick", tk, 0);
        for (int k = 0; k < 3; k++) begin
            step(h1, h2, tk, ak);
            check($sformatf("d0 c%0d s_out hi", k), h1, 0);
            check($sformatf("d0 c%0d s_out lo", k), h2, 0);
            check($sformatf("d0 c%0d tick", k), tk, 0);
        end

        // Back to 4, leave 7 pending, then reset mid-period.
        bus.div_load = 1'b1; bus.div_in = 4;
        step(h1, h2, tk, ak);
        bus.div_load = 1'b0;
        step(h1, h2, tk, ak);
        check("d4 apply ack", ak, 1);
        check("d4 apply tick", tk, 1);
        step(h1, h2, tk, ak);
        bus.div_load = 1'b1; bus.div_in = 7;
        step(h1, h2, tk, ak);
        bus.div_load = 1'b0;
        check("pre-reset s_out", h2, 1);
        rst_n = 1'b0;
        #1;
        check("async reset s_out", bus.s_out, 0);
        check("async reset tick", bus.tick, 0);
        check("async reset ack", bus.div_ack, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(h1, h2, tk, ak);
            check($sformatf("post-reset c%0d s_out", k), h1, (k % 4) >= 2);
            check($sformatf("post-reset c%0d tick", k), tk, (k % 4) == 0);
            check($sformatf("post-reset c%0d ack", k), ak, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frqdiv_prog.md
FRQDIV_PROG -- requirements
Module: frqdiv_prog

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the divisor and the phase counter.
REQ-002 Parameter DIV_INIT, default 2, active divisor after reset; SHALL satisfy 0 <= DIV_INIT < 2^WIDTH.
REQ-003 clk  input  1  the single clock; every flop is clocked by clk, on the posedge, or on the negedge for the odd-divisor half-cycle stage.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  run enable; when low, the divider is stopped and the output is held low.
REQ-006 div_in  input  WIDTH  new divisor value, sampled while div_load is high.
REQ-007 div_load  input  1  one-cycle request to capture div_in as the pending divisor.
REQ-008 sync  input  1  one-cycle request to restart the output period at phase 0.
REQ-009 s_out  output  1  divided clock, 50% duty for every divisor >= 2.
REQ-010 tick  output  1  one-clk-cycle pulse marking the first cycle of each output period.
REQ-011 div_ack  output  1  one-cycle pulse, high in the first cycle that runs with a newly applied divisor.

Function
REQ-012 Registers SHALL be: D_act (active divisor), D_pend plus a pend flag, and cnt (phase 0..D_act-1, posedge); "cycle k" is the clk cycle in which cnt==k.
REQ-013 While en=1, sync=0 and D_act>=2, cnt SHALL increment by 1 each posedge and wrap from D_act-1 to 0.
REQ-014 A period boundary SHALL be the posedge that ends cycle D_act-1.
REQ-015 div_load=1 SHALL write div_in into D_pend and set pend at that posedge; a second load before application SHALL overwrite D_pend and produce only one div_ack.
REQ-016 If pend=1 at a boundary, D_act SHALL take D_pend, pend SHALL clear, cnt SHALL go to 0, and div_ack SHALL be high during the following cycle.
REQ-017 A div_load whose capture posedge is itself a boundary SHALL be applied at the next boundary, not the current one.
REQ-018 If D_act<=1, or en=0, a pending divisor SHALL apply at the first posedge where pend=1, without waiting for a boundary.
REQ-019 sync=1 (with en=1) SHALL force cnt to 0 at that posedge, SHALL apply any pending divisor there, and SHALL take priority over the normal boundary.
REQ-020 Even D_act: s_out=0 in cycles 0..D/2-1 and s_out=1 in cycles D/2..D-1.
REQ-021 Odd D_act>=3: s_out=0 from the start of cycle 0 to the negedge inside cycle (D-1)/2, then 1 until the end of cycle D-1 (exactly D/2 clk periods high).
REQ-022 For D_act>=2, s_out SHALL be the OR of a posedge flop and a negedge flop only, with no combinational glitches; the negedge flop SHALL be forced low whenever D_act is even.
REQ-023 D_act=1: s_out SHALL equal clk while en=1 and 0 while en=0; en SHALL be re-timed on the negedge so the gated output has no runt pulses; tick SHALL be held 1 while en=1.
REQ-024 D_act=0: the divider is stopped; cnt=0, s_out=0, tick=0.
REQ-025 tick SHALL be 1 exactly in cycle 0 of each period while en=1 and D_act>=2.
REQ-026 en falling: at the next posedge cnt SHALL go to 0 and tick SHALL go to 0; s_out SHALL go low at that posedge (or at the following negedge for the negedge stage) and stay low.
REQ-027 en rising: the first cycle with en=1 SHALL be cycle 0.
REQ-028 Width rule: all comparisons SHALL use WIDTH-bit unsigned values; D/2 and (D-1)/2 SHALL be computed from D_act with no loss of precision.

Reset
REQ-029 rst_n=0 SHALL asynchronously set D_act=DIV_INIT, D_pend=0, pend=0, cnt=0, s_out=0, tick=0, div_ack=0, and clear the negedge flop.
REQ-030 Reset released mid-period SHALL start at cycle 0 on the first posedge where en=1.
REQ-031 A pending divisor present when reset asserts SHALL be discarded.

Verification
REQ-032 DIV_INIT=4, en=1 -> s_out pattern 0,0,1,1 repeating; tick high every 4th cycle, in cycle 0.
REQ-033 Load 5 -> after the next boundary, s_out low for 2.5 clk periods and high for 2.5; div_ack pulses once, in the first cycle at D_act=5.
REQ-034 div_load of 6 exactly at a boundary -> the current period completes at the old divisor, one further period runs at the old divisor, then D_act=6.
REQ-035 Two loads (3, then 8) within one period -> only 8 is applied; exactly one div_ack.
REQ-036 sync asserted in cycle 2 of D=6 -> next cycle is cycle 0 with tick=1 and s_out=0.
REQ-037 D=1 then en toggled mid-high-phase -> no runt pulse on s_out; load 0 -> s_out=0 and tick=0 continuously; rst_n pulse mid-period -> all outputs 0 immediately.
